// File: rtl/rgbd_frame_streamer_pkg.sv
// rgbd_frame_streamer_pkg: shared widths and FSM encoding for the frame streamer
package rgbd_frame_streamer_pkg;
  localparam int FRAME_ADDR_BW = 19;
  localparam int FRAME_PIX_BW = 20;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FLUSH} streamer_state_t;
endpackage

// File: rtl/rgbd_stream_fifo.sv
// rgbd_stream_fifo: synchronous FIFO for tagged pixel/depth beats with occupancy count
module rgbd_stream_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && count != CW'(DEPTH);
  assign do_pop = pop && count != '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/rgbd_frame_streamer.sv
// rgbd_frame_streamer: streams pixel+depth frames from frame memory with repeat passes,
// credit-limited reads and a ready/valid output FIFO.
module rgbd_frame_streamer
  import rgbd_frame_streamer_pkg::*;
#(
  parameter int DATA_BW = 8,
  parameter int DEPTH_BW = 16,
  parameter int ADDR_BW = FRAME_ADDR_BW,
  parameter int NUM_CH = 3,
  parameter int MEM_LAT = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_BW = 4,
  localparam int CH_BW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [CH_BW-1:0]          i_ch,
  input  logic [REP_BW-1:0]         i_repeat,
  input  logic                      i_abort,
  input  logic [NUM_CH*ADDR_BW-1:0] r_base,
  input  logic [9:0]                r_hsize,
  input  logic [9:0]                r_vsize,
  output logic                      o_rd_en,
  output logic [ADDR_BW-1:0]        o_rd_addr,
  input  logic [DATA_BW-1:0]        i_rd_pixel,
  input  logic [DEPTH_BW-1:0]       i_rd_depth,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [DATA_BW-1:0]        o_pixel,
  output logic [DEPTH_BW-1:0]       o_depth,
  output logic                      o_frame_start,
  output logic                      o_frame_end,
  output logic [REP_BW-1:0]         o_pass_cnt,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_aborted
);
  localparam int TAG_W = REP_BW + 2;
  localparam int FW = DATA_BW + DEPTH_BW + TAG_W;
  localparam int FC_W = $clog2(FIFO_DEPTH + 1);
  localparam int OC_W = $clog2(FIFO_DEPTH + MEM_LAT + 1);
  streamer_state_t state, next_state;
  logic [REP_BW-1:0] rep_q, pass_issue;
  logic [FRAME_PIX_BW-1:0] npix_q, pix_cnt, npix_in;
  logic [ADDR_BW-1:0] base_q, rd_addr, base_in;
  logic [MEM_LAT-1:0] vld;
  logic [TAG_W-1:0] tag_pipe [MEM_LAT];
  logic [FC_W-1:0] fifo_count;
  logic [OC_W-1:0] outstanding;
  logic [FW-1:0] fifo_dout;
  logic live, last_pix, fifo_clr, fifo_push, fifo_pop;
  assign npix_in = FRAME_PIX_BW'(r_hsize) * FRAME_PIX_BW'(r_vsize);
  assign base_in = r_base[i_ch*ADDR_BW +: ADDR_BW];
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < MEM_LAT; i++) outstanding = outstanding + OC_W'(vld[i]);
  end
  // credit counts reads still in the memory pipe as already occupying the FIFO
  assign o_rd_en = state == STREAM && (outstanding + OC_W'(fifo_count) < OC_W'(FIFO_DEPTH));
  assign o_rd_addr = rd_addr;
  assign last_pix = pix_cnt == npix_q - 1'b1;
  assign live = state == STREAM || state == DRAIN;
  assign fifo_clr = live && i_abort;
  assign fifo_push = live && vld[MEM_LAT-1];
  assign fifo_pop = o_valid && i_ready;
  assign o_valid = fifo_count != '0;
  assign {o_pixel, o_depth, o_frame_start, o_frame_end, o_pass_cnt} = o_valid ? fifo_dout : '0;
  assign o_busy = state != IDLE;
  assign o_done = state == DRAIN && !i_abort && outstanding == '0 && fifo_count == '0;
  assign o_aborted = state == FLUSH && outstanding == '0;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = !i_start ? IDLE : (npix_in == '0 ? DRAIN : STREAM);
      STREAM:  next_state = i_abort ? FLUSH : (o_rd_en && last_pix && pass_issue == rep_q) ? DRAIN : STREAM;
      DRAIN:   next_state = i_abort ? FLUSH : o_done ? IDLE : DRAIN;
      FLUSH:   next_state = o_aborted ? IDLE : FLUSH;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      rep_q <= '0;
      pass_issue <= '0;
      npix_q <= '0;
      pix_cnt <= '0;
      base_q <= '0;
      rd_addr <= '0;
      vld <= '0;
      for (int i = 0; i < MEM_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      state <= next_state;
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        vld[i] <= vld[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      vld[0] <= o_rd_en;
      tag_pipe[0] <= {pix_cnt == '0, last_pix, pass_issue};
      if (state == IDLE && i_start) begin
        rep_q <= i_repeat;
        npix_q <= npix_in;
        base_q <= base_in;
        rd_addr <= base_in;
        pix_cnt <= '0;
        pass_issue <= '0;
      end else if (o_rd_en) begin
        pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
        rd_addr <= last_pix ? base_q : rd_addr + 1'b1;
        pass_issue <= pass_issue + REP_BW'(last_pix);
      end
    end
  end
  rgbd_stream_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .clr(fifo_clr),
    .push(fifo_push),
    .din({i_rd_pixel, i_rd_depth, tag_pipe[MEM_LAT-1]}),
    .pop(fifo_pop),
    .dout(fifo_dout),
    .count(fifo_count)
  );
endmodule
